// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline register with the architectural condition-code register (CCR).
// Optional FLAG_PRESERVE_EN adds intSave/rtiRestore and a shadow CCR for interrupt entry/return.
module ex_mem_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              inValid,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ALUfirstOperand,
  input  logic [3:0]        newStatus,
  input  logic [2:0]        flagWrite,
  input  logic              setCarry,
  input  logic              clrCarry,
  input  logic [2:0]        flagClear,
  input  logic              writeBack,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [REG_AW-1:0] destReg,
`ifdef FLAG_PRESERVE_EN
  input  logic              intSave,
  input  logic              rtiRestore,
`endif
  output logic              exValid,
  output logic [DATA_W-1:0] exALUResult,
  output logic [DATA_W-1:0] exStoreData,
  output logic [REG_AW-1:0] exDestReg,
  output logic              exWriteBack,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic [2:0]        flags
);

  logic [2:0] ccrNext;
  logic       advance;
  logic       unusedStatusValid;

  // The execute stage's own valid bit in newStatus is redundant with inValid.
  assign unusedStatusValid = newStatus[3];
  assign advance = !stall && !flush;

  // Lowest priority applied first so later assignments win per bit: write, carry force, clear.
  always_comb begin
    ccrNext = flags;
    for (int i = 0; i < 3; i++) begin
      if (flagWrite[i]) ccrNext[i] = newStatus[i];
    end
    if (clrCarry) ccrNext[2] = 1'b0;
    if (setCarry) ccrNext[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (flagClear[i]) ccrNext[i] = 1'b0;
    end
  end

`ifdef FLAG_PRESERVE_EN
  logic [2:0] shadow;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      exValid     <= 1'b0;
      exALUResult <= '0;
      exStoreData <= '0;
      exDestReg   <= '0;
      exWriteBack <= 1'b0;
      exMemRead   <= 1'b0;
      exMemWrite  <= 1'b0;
      flags       <= 3'b000;
`ifdef FLAG_PRESERVE_EN
      shadow      <= 3'b000;
`endif
    end else begin
      if (flush) begin
        exValid     <= 1'b0;
        exWriteBack <= 1'b0;
        exMemRead   <= 1'b0;
        exMemWrite  <= 1'b0;
        exALUResult <= ALUResult;
        exStoreData <= ALUfirstOperand;
        exDestReg   <= destReg;
      end else if (!stall) begin
        exValid     <= inValid;
        exALUResult <= ALUResult;
        exStoreData <= ALUfirstOperand;
        exDestReg   <= destReg;
        exWriteBack <= writeBack && inValid;
        exMemRead   <= memRead && inValid;
        exMemWrite  <= memWrite && inValid;
        if (inValid) flags <= ccrNext;
      end
`ifdef FLAG_PRESERVE_EN
      // Restore overrides every other CCR source, even under stall or flush.
      if (rtiRestore) begin
        flags <= shadow;
      end else if (intSave && advance) begin
        shadow <= inValid ? ccrNext : flags;
      end
`endif
    end
  end

endmodule
